// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, lane/word sizes, address checks.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int ADDR_W     = 32;

    // Misaligned or beyond the last word of a depth_words-deep memory.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth_words);
        return (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= 30'(depth_words));
    endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Word storage for dmem_bus_responder: byte-lane synchronous write, registered synchronous read.
module dmem_resp_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_idx,
    input  logic [WORD_W-1:0]     i_wdata,
    input  logic [WORD_BYTES-1:0] i_be,
    output logic [WORD_W-1:0]     o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Lane-masked write; the storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read data register, held until the next read.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_bus_responder.sv
// Single-outstanding data-memory slave with LATENCY wait cycles and a held response.
// Optional access error reporting is enabled by defining DMEM_RESP_ERR_EN.
module dmem_bus_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_MEM_DEPTH = 256,
    parameter int LATENCY        = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [WORD_W-1:0]     req_wdata,
    input  logic [WORD_BYTES-1:0] req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int         AW       = $clog2(DATA_MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_state_t            r_state;
    mem_state_t            w_next_state;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [WORD_W-1:0]     r_wdata;
    logic [WORD_BYTES-1:0] r_be;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_acc_we;
    logic [ADDR_W-1:0]     w_acc_addr;
    logic [WORD_W-1:0]     w_acc_wdata;
    logic [WORD_BYTES-1:0] w_acc_be;
    logic                  w_acc_err;
    logic                  w_arr_we;
    logic                  w_arr_re;
    logic [WORD_W-1:0]     w_arr_rdata;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // A zero-latency access commits on the accepting edge, so it must use the live request.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_acc_we    = req_we;
            w_acc_addr  = req_addr;
            w_acc_wdata = req_wdata;
            w_acc_be    = req_be;
        end else begin
            w_acc_we    = r_we;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
            w_acc_be    = r_be;
        end
    end

`ifdef DMEM_RESP_ERR_EN
    assign w_acc_err = addr_err(w_acc_addr, DATA_MEM_DEPTH);
`else
    logic w_unused_addr;
    assign w_acc_err     = 1'b0;
    assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[ADDR_W-1:AW+2]};
`endif

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_next_state = ST_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                        w_cnt_next   = LAT_LOAD;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // Reset gates the array so an uncommitted store can never land.
    assign w_arr_we = w_commit && w_acc_we && !w_acc_err && !rst;
    assign w_arr_re = w_commit && !w_acc_we && !rst;

    // State register, request latch and error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_commit) begin
                r_err <= w_acc_err;
            end
        end
    end

    dmem_resp_array #(
        .DEPTH (DATA_MEM_DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_idx   (w_acc_addr[AW+1:2]),
        .i_wdata (w_acc_wdata),
        .i_be    (w_acc_be),
        .o_rdata (w_arr_rdata)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = (rsp_valid && !r_we && !r_err) ? w_arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Bench for dmem_bus_responder: three instances (LATENCY 1, 3, 0) checked against a byte-level memory model.
module tb_dmem_bus_responder;

    localparam int DEPTH = 256;
    localparam int NI    = 3;
    int lat_c [NI] = '{1, 3, 0};

    logic              clk = 1'b0;
    logic [NI-1:0]     rst_v;
    logic [NI-1:0]     req_valid_v;
    logic [NI-1:0]     req_we_v;
    logic [NI-1:0]     rsp_ready_v;
    logic [31:0]       req_addr_a  [NI];
    logic [31:0]       req_wdata_a [NI];
    logic [3:0]        req_be_a    [NI];
    wire  [NI-1:0]     req_ready_v;
    wire  [NI-1:0]     rsp_valid_v;
    wire  [NI-1:0]     rsp_err_v;
    wire  [31:0]       rsp_rdata_a [NI];

    logic [7:0] mb [NI][DEPTH*4];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_bus_responder #(.DATA_MEM_DEPTH(DEPTH), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
        .req_we(req_we_v[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]), .req_be(req_be_a[0]),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready_v[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_v[0]));
    dmem_bus_responder #(.DATA_MEM_DEPTH(DEPTH), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
        .req_we(req_we_v[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]), .req_be(req_be_a[1]),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready_v[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_v[1]));
    dmem_bus_responder #(.DATA_MEM_DEPTH(DEPTH), .LATENCY(0)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
        .req_we(req_we_v[2]), .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]), .req_be(req_be_a[2]),
        .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready_v[2]), .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] addr);
`ifdef DMEM_RESP_ERR_EN
        return (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] addr);
        int base;
        base = int'((addr / 4) % DEPTH) * 4;
        return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
    endfunction

    task automatic model_store(input int d, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        int base;
        base = int'((addr / 4) % DEPTH) * 4;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mb[d][base+i] = wdata[i*8 +: 8];
        end
    endtask

    // One full transaction: request, latency check, optional backpressure, handoff.
    task automatic xact(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] rd);
        int n;
        logic [31:0] exp_rd;
        logic exp_err;
        exp_err = model_err(addr);
        exp_rd  = (!we && !exp_err) ? model_word(d, addr) : 32'd0;
        req_valid_v[d] = 1'b1; req_we_v[d] = we; req_addr_a[d] = addr;
        req_wdata_a[d] = wdata; req_be_a[d] = be;
        n = 0;
        while (!req_ready_v[d] && n < 20) begin @(posedge clk); #1; n++; end
        chk("req_ready_idle", {31'd0, req_ready_v[d]}, 32'd1);
        @(posedge clk); #1;
        req_valid_v[d] = 1'b0;
        n = 0;
        while (!rsp_valid_v[d] && n < 40) begin @(posedge clk); #1; n++; end
        chk("accept_to_rsp_latency", 32'(n + 1), 32'(lat_c[d] + 1));
        chk("rsp_rdata", rsp_rdata_a[d], exp_rd);
        chk("rsp_err", {31'd0, rsp_err_v[d]}, {31'd0, exp_err});
        rd = rsp_rdata_a[d];
        for (int h = 0; h < hold; h++) begin
            req_valid_v[d] = 1'b1; req_we_v[d] = 1'b1; req_be_a[d] = 4'hF;
            req_wdata_a[d] = ~wdata;
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'd0, rsp_valid_v[d]}, 32'd1);
            chk("bp_rdata_stable", rsp_rdata_a[d], exp_rd);
            chk("bp_req_ready_low", {31'd0, req_ready_v[d]}, 32'd0);
        end
        req_valid_v[d] = 1'b0;
        rsp_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready_v[d] = 1'b0;
        chk("handoff_rsp_valid_low", {31'd0, rsp_valid_v[d]}, 32'd0);
        chk("handoff_req_ready", {31'd0, req_ready_v[d]}, 32'd1);
        if (we && !exp_err) model_store(d, addr, wdata, be);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        rst_v = '1; req_valid_v = '0; req_we_v = '0; rsp_ready_v = '0;
        for (int d = 0; d < NI; d++) begin
            req_addr_a[d] = 32'd0; req_wdata_a[d] = 32'd0; req_be_a[d] = 4'd0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) begin
            chk("reset_req_ready", {31'd0, req_ready_v[d]}, 32'd1);
            chk("reset_rsp_valid", {31'd0, rsp_valid_v[d]}, 32'd0);
            chk("reset_rsp_rdata", rsp_rdata_a[d], 32'd0);
            chk("reset_rsp_err", {31'd0, rsp_err_v[d]}, 32'd0);
        end
        rst_v = '0;

        // Give every word of instance 0 a known value
        for (int w = 0; w < DEPTH; w++) begin
            xact(0, 1'b1, 32'(w * 4), {8'(w), 8'hA5, 8'(~w), 8'h5A}, 4'hF, 0, rd);
        end

        // Full-word store/load, then byte-enable merge
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_deadbeef", rd, 32'hDEADBEEF);
        xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rd);
        chk("store_rdata_zero", rd, 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_be_merge", rd, 32'hDE22BE44);

        // Backpressure with a competing request, then be=0 store leaves word intact
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
        xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1, rd);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_after_bp_and_be0", rd, 32'hDE22BE44);

        // Reset during WAIT drops an uncommitted store
        xact(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 0, rd);
        req_valid_v[1] = 1'b1; req_we_v[1] = 1'b1; req_addr_a[1] = 32'h20;
        req_wdata_a[1] = 32'h0000CAFE; req_be_a[1] = 4'hF;
        @(posedge clk); #1;
        req_valid_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_v[1] = 1'b1;
        @(posedge clk); #1;
        rst_v[1] = 1'b0;
        chk("midwait_reset_ready", {31'd0, req_ready_v[1]}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("midwait_no_rsp", {31'd0, rsp_valid_v[1]}, 32'd0);
        end
        xact(1, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("midwait_prior_contents", rd, 32'h12345678);

        // Zero-latency instance
        xact(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd);
        xact(2, 1'b1, 32'h40, 32'h00990000, 4'b0100, 2, rd);
        xact(2, 1'b0, 32'h40, 32'h0, 4'h0, 2, rd);
        chk("lat0_merge", rd, 32'hCA99F00D);

        // Error / wrap behaviour
        xact(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, rd);
        xact(0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 0, rd);
        xact(0, 1'b0, 32'h413, 32'h0, 4'h0, 0, rd);
`ifdef DMEM_RESP_ERR_EN
        chk("err_load_rdata_zero", rd, 32'd0);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
        chk("err_store_no_write", rd, {8'd0, 8'hA5, 8'hFF, 8'h5A});
`else
        chk("wrap_load_0x413", rd, 32'hDE22BE44);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 60; k++) begin
            a  = 32'($urandom_range(0, 32'h7FF));
            wd = $urandom;
            xact(0, 1'($urandom_range(0, 1)), a, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 2), rd);
        end
        for (int k = 0; k < 8; k++) begin
            for (int d = 1; d < NI; d++) begin
                a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
                wd = $urandom;
                xact(d, 1'b1, a, wd, 4'hF, 0, rd);
                xact(d, 1'b0, a, 32'h0, 4'h0, $urandom_range(0, 2), rd);
                chk("rand_store_load", rd, wd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
